calc_w_search: RTL and testbench

Sequential inverse of the team's MOSFET drain-current / transconductance calculator. Given a bias point (V_GS, V_DS), a quantity select and a 10-bit target, it sweeps device width W from 1 to 7, one candidate per clock. It reports the smallest W whose computed value reaches the target. It sits downstream of the operand registers in the sizing path and hands its result to the layout-parameter stage through a start/done handshake.

---
 rtl/calc_w_search_if.sv | 23 ++
 rtl/calc_w_search.sv | 99 +++++++++
 tb/tb_calc_w_search.sv | 130 +++++++++++++
 3 files changed

// File: rtl/calc_w_search_if.sv
// Start/done handshake and operand/result bundle between the sizing path and the W search.
interface calc_w_search_if;
  logic       start;
  logic [2:0] V_GS;
  logic [2:0] V_DS;
  logic       mode;
  logic [9:0] target;
  logic       busy;
  logic       done;
  logic       found;
  logic [2:0] W_out;
  logic [9:0] out_val;

  modport master (
    output start, V_GS, V_DS, mode, target,
    input  busy, done, found, W_out, out_val
  );

  modport slave (
    input  start, V_GS, V_DS, mode, target,
    output busy, done, found, W_out, out_val
  );
endinterface

// File: rtl/calc_w_search.sv
// Sweeps device width W = 1..7, one per clock, and returns the smallest W whose
// drain current (mode=1) or transconductance (mode=0) reaches the target.
module calc_w_search (
  input  logic            clk,
  input  logic            rst,
  calc_w_search_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  state_t      state, state_nxt;
  logic [2:0]  vgs_p0, vds_p0, w_p0;
  logic        mode_p0;
  logic [9:0]  target_p0;
  logic [9:0]  val;
  logic        hit, last, accept;

  // Operands stay non-negative, so truncating division equals floor division.
  function automatic logic [9:0] model_val(input logic [2:0] w, input logic [2:0] vgs,
                                           input logic [2:0] vds, input logic mode);
    logic signed [11:0] ov, vd, ww, num;
    ov = $signed({9'd0, vgs}) - 12'sd1;
    vd = $signed({9'd0, vds});
    ww = $signed({9'd0, w});
    if (vgs <= 3'd1)
      num = 12'sd0;
    else if (ov > vd)
      num = mode ? ww * (12'sd2 * ov * vd - vd * vd) : 12'sd2 * ww * vd;
    else
      num = mode ? ww * ov * ov : 12'sd2 * ww * ov;
    return 10'(num / 12'sd3);
  endfunction

  assign accept = (state == IDLE) && bus.start;

  // Stage p0: operands latched on an accepted start
  always_ff @(posedge clk) begin
    if (accept) begin
      vgs_p0    <= bus.V_GS;
      vds_p0    <= bus.V_DS;
      mode_p0   <= bus.mode;
      target_p0 <= bus.target;
    end
  end

  always_comb begin
    val  = model_val(w_p0, vgs_p0, vds_p0, mode_p0);
    hit  = (val >= target_p0);
    last = (w_p0 == 3'd7);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = EVAL;
      EVAL:    if (hit || last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state != IDLE);
    bus.done = (state == DONE);
  end

  // Stage p1: candidate counter and registered result, held until the next accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      w_p0        <= 3'd0;
      bus.found   <= 1'b0;
      bus.W_out   <= 3'd0;
      bus.out_val <= 10'd0;
    end else if (accept) begin
      w_p0        <= 3'd1;
      bus.found   <= 1'b0;
      bus.W_out   <= 3'd0;
      bus.out_val <= 10'd0;
    end else if (state == EVAL) begin
      if (hit) begin
        bus.found   <= 1'b1;
        bus.W_out   <= w_p0;
        bus.out_val <= val;
      end else if (last) begin
        bus.found   <= 1'b0;
        bus.W_out   <= 3'd0;
        bus.out_val <= val;
      end else begin
        w_p0 <= w_p0 + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_calc_w_search.sv
// Directed bench for calc_w_search: hand-computed searches, protocol and reset cases.
module tb_calc_w_search;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  calc_w_search_if bus ();

  calc_w_search dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called just after a negedge in an IDLE cycle; returns just after the negedge
  // of the IDLE cycle that follows DONE.
  task automatic run_search(input string tag, input int vgs, input int vds, input int md,
                            input int tgt, input int efound, input int ew, input int eval,
                            input int elat, input bit glitch, input bit start_in_done);
    int lat;
    bus.V_GS   = 3'(vgs);
    bus.V_DS   = 3'(vds);
    bus.mode   = 1'(md);
    bus.target = 10'(tgt);
    bus.start  = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    lat = 1;
    chk({tag, "_busy_rise"}, int'(bus.busy), 1);
    while (!bus.done && lat < 20) begin
      if (glitch && lat == 2) begin
        bus.start = 1'b1; bus.V_GS = 3'd7; bus.V_DS = 3'd3; bus.mode = 1'b1; bus.target = 10'd0;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    chk({tag, "_latency"}, lat, elat);
    chk({tag, "_found"}, int'(bus.found), efound);
    chk({tag, "_W_out"}, int'(bus.W_out), ew);
    chk({tag, "_out_val"}, int'(bus.out_val), eval);
    if (start_in_done) begin
      bus.start = 1'b1; bus.V_GS = 3'd1; bus.V_DS = 3'd0; bus.mode = 1'b0; bus.target = 10'd0;
    end
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "_busy_fall"}, int'(bus.busy), 0);
    chk({tag, "_done_width"}, int'(bus.done), 0);
    chk({tag, "_hold_W_out"}, int'(bus.W_out), ew);
    chk({tag, "_hold_out_val"}, int'(bus.out_val), eval);
  endtask

  initial begin
    bit seen_done;

    // rst and start together: rst wins
    rst = 1'b1;
    bus.start = 1'b1; bus.V_GS = 3'd4; bus.V_DS = 3'd5; bus.mode = 1'b1; bus.target = 10'd10;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_found", int'(bus.found), 0);
    chk("rst_W_out", int'(bus.W_out), 0);
    chk("rst_out_val", int'(bus.out_val), 0);
    rst = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    chk("idle_busy", int'(bus.busy), 0);

    // ID saturation: 3W, first reaching 10 at W=4
    run_search("id_sat", 4, 5, 1, 10, 1, 4, 12, 5, 1'b0, 1'b0);
    // gm triode: 1,2,4,5,6,8,9
    run_search("gm_tri_hit", 7, 2, 0, 9, 1, 7, 9, 8, 1'b0, 1'b0);
    run_search("gm_tri_miss", 7, 2, 0, 10, 0, 0, 9, 8, 1'b0, 1'b0);
    // ID triode: 9W
    run_search("id_tri", 7, 3, 1, 50, 1, 6, 54, 7, 1'b0, 1'b0);
    // Cutoff
    run_search("cut_t0", 1, 3, 1, 0, 1, 1, 0, 2, 1'b0, 1'b0);
    run_search("cut_t1", 1, 6, 0, 1, 0, 0, 0, 8, 1'b0, 1'b0);
    // Maximum value 12*7 = 84
    run_search("max_hit", 7, 7, 1, 84, 1, 7, 84, 8, 1'b0, 1'b0);
    run_search("max_miss", 7, 7, 1, 85, 0, 0, 84, 8, 1'b0, 1'b0);
    // start during EVAL and during DONE must be ignored
    run_search("glitch", 4, 5, 1, 10, 1, 4, 12, 5, 1'b1, 1'b1);
    chk("after_done_start_found", int'(bus.found), 1);

    // rst mid-search at W=3
    bus.V_GS = 3'd7; bus.V_DS = 3'd2; bus.mode = 1'b0; bus.target = 10'd100;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_done", int'(bus.done), 0);
    chk("midrst_found", int'(bus.found), 0);
    chk("midrst_W_out", int'(bus.W_out), 0);
    chk("midrst_out_val", int'(bus.out_val), 0);
    rst = 1'b0;
    seen_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) seen_done = 1'b1;
    end
    chk("midrst_no_done", int'(seen_done), 0);

    run_search("post_rst", 4, 5, 1, 10, 1, 4, 12, 5, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
